btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_pkg.sv | 22 ++
 rtl/btn_channel.sv | 104 ++++++++++
 rtl/btn_conditioner.sv | 62 ++++++
 tb/tb_btn_conditioner.sv | 133 +++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner: FSM state encoding,
// btn_raw bit positions and a constant helper for counter sizing.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_t;

    localparam int BTN_P1_UP   = 0;
    localparam int BTN_P1_DOWN = 1;
    localparam int BTN_P2_UP   = 2;
    localparam int BTN_P2_DOWN = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchronizer, stability debouncer and press/auto-repeat
// FSM. The step pulse is combinational; the top registers it.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES     = 50000,
    parameter int REPEAT_DELAY   = 12500000,
    parameter int REPEAT_PERIOD  = 1250000,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int CNT_W = $clog2(max3(DEB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic             INV      = (BTN_ACTIVE_LOW != 0);

    logic             sync_p0, sync_p1;
    logic [CNT_W-1:0] deb_cnt;
    btn_state_t       state, state_nxt;
    logic [CNT_W-1:0] timer, timer_nxt;

    // Stage 0/1: polarity folded in ahead of the synchronizer so reset value 0 is "released"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw ^ INV;
            sync_p1 <= sync_p0;
        end
    end

    // Debouncer: counts consecutive cycles the synchronized input disagrees with the level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt <= '0;
            level   <= 1'b0;
        end else if (sync_p1 == level) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            deb_cnt <= '0;
            level   <= ~level;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        pulse     = 1'b0;
        if (!level) begin
            state_nxt = ST_IDLE;
            timer_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_HOLD;
                    timer_nxt = '0;
                    pulse     = 1'b1;
                end
                ST_HOLD: begin
                    if (timer == RD_LAST) begin
                        state_nxt = ST_REPEAT;
                        timer_nxt = '0;
                        pulse     = 1'b1;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (timer == RP_LAST) begin
                        timer_nxt = '0;
                        pulse     = 1'b1;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    timer_nxt = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Four debounced, auto-repeating paddle buttons with per-player up/down
// conflict masking and registered one-cycle step pulses.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES     = 50000,
    parameter int REPEAT_DELAY   = 12500000,
    parameter int REPEAT_PERIOD  = 1250000,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_raw,
    output logic       ply1_up,
    output logic       ply1_down,
    output logic       ply2_up,
    output logic       ply2_down,
    output logic [3:0] btn_level
);

    logic [3:0] level;
    logic [3:0] pulse_p0;
    logic [3:0] pulse_p1;
    logic [3:0] pulse_mask;
    logic       p1_conflict, p2_conflict;

    for (genvar i = 0; i < 4; i++) begin : g_ch
        btn_channel #(
            .DEB_CYCLES    (DEB_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)
        ) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (btn_raw[i]),
            .level(level[i]),
            .pulse(pulse_p0[i])
        );
    end

    // The FSMs keep running under conflict; only the outputs are suppressed
    assign p1_conflict = level[BTN_P1_UP] & level[BTN_P1_DOWN];
    assign p2_conflict = level[BTN_P2_UP] & level[BTN_P2_DOWN];
    assign pulse_mask  = {{2{~p2_conflict}}, {2{~p1_conflict}}};

    // Stage p1: registered step pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_p1 <= '0;
        end else begin
            pulse_p1 <= pulse_p0 & pulse_mask;
        end
    end

    assign ply1_up   = pulse_p1[BTN_P1_UP];
    assign ply1_down = pulse_p1[BTN_P1_DOWN];
    assign ply2_up   = pulse_p1[BTN_P2_UP];
    assign ply2_down = pulse_p1[BTN_P2_DOWN];
    assign btn_level = level;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEB=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_btn_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic       ply1_up, ply1_down, ply2_up, ply2_down;
    logic [3:0] btn_level;

    int checks   = 0;
    int failures = 0;
    int e        = 0;

    btn_conditioner #(
        .DEB_CYCLES    (4),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (3),
        .BTN_ACTIVE_LOW(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .ply1_up  (ply1_up),
        .ply1_down(ply1_down),
        .ply2_up  (ply2_up),
        .ply2_down(ply2_down),
        .btn_level(btn_level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        e++;
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] exp_p, input logic [3:0] exp_l);
        logic [3:0] obs_p;
        obs_p = {ply2_down, ply2_up, ply1_down, ply1_up};
        checks++;
        assert (obs_p === exp_p) else begin
            failures++;
            $error("FAIL %s pulses edge=%0d observed=%b expected=%b", tag, e, obs_p, exp_p);
        end
        checks++;
        assert (btn_level === exp_l) else begin
            failures++;
            $error("FAIL %s btn_level edge=%0d observed=%b expected=%b", tag, e, btn_level, exp_l);
        end
    endtask

    initial begin
        logic [3:0] ep, el;
        rst_n   = 1'b0;
        btn_raw = 4'hF;

        // Reset state
        tick();
        tick();
        check("reset", 4'b0000, 4'b0000);
        rst_n = 1'b1;
        tick();
        tick();
        tick();

        // Press ply1 up after edge 5, hold, release after edge 30
        btn_raw[0] = 1'b0;
        for (int i = 6; i <= 45; i++) begin
            tick();
            ep = {3'b000, (e inside {12, 22, 25, 28, 31, 34})};
            el = {3'b000, (e >= 11 && e <= 35)};
            check("press_repeat", ep, el);
            if (e == 30) btn_raw[0] = 1'b1;
        end

        // Glitches of 3 cycles with 1-cycle gaps on ply2 up
        for (int rep = 0; rep < 5; rep++) begin
            btn_raw[2] = 1'b0;
            for (int j = 0; j < 3; j++) begin
                tick();
                check("glitch_low", 4'b0000, 4'b0000);
            end
            btn_raw[2] = 1'b1;
            tick();
            check("glitch_gap", 4'b0000, 4'b0000);
        end
        for (int j = 0; j < 6; j++) begin
            tick();
            check("glitch_after", 4'b0000, 4'b0000);
        end

        // Ply1 up+down conflict, release down after r=18, up after r=33
        btn_raw[1:0] = 2'b00;
        for (int r = 1; r <= 45; r++) begin
            tick();
            ep = {3'b000, (r inside {26, 29, 32, 35, 38})};
            el = {2'b00, (r >= 6 && r <= 23), (r >= 6 && r <= 38)};
            check("conflict", ep, el);
            if (r == 18) btn_raw[1] = 1'b1;
            if (r == 33) btn_raw[0] = 1'b1;
        end

        // Ply2 down held into REPEAT, reset while a pulse is on the output
        btn_raw[3] = 1'b0;
        for (int r = 1; r <= 23; r++) begin
            tick();
            ep = {(r inside {7, 17, 20, 23}), 3'b000};
            el = {(r >= 6), 3'b000};
            check("p2_hold", ep, el);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", 4'b0000, 4'b0000);
        tick();
        check("reset_hold1", 4'b0000, 4'b0000);
        tick();
        check("reset_hold2", 4'b0000, 4'b0000);
        #4;
        rst_n = 1'b1;
        for (int r = 1; r <= 12; r++) begin
            tick();
            ep = {(r == 7), 3'b000};
            el = {(r >= 6), 3'b000};
            check("post_reset", ep, el);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
